dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder on the LSU data port; services the core's load/store requests.
- Sits opposite the memory stage: accepts address, store data and byte strobes from the LSU and returns the raw 32-bit word as lsu_rdata.
- Word-addressed synchronous RAM behind a valid/ready request channel and a valid/ready response channel.
- Programmable wait states; one request in flight at a time.

Parameters:
DEPTH_WORDS  1024  number of 32-bit words; power of two, >= 2
WAIT_STATES  1     extra cycles between request accept and response valid; 0..15
ADDR_W       32    request byte-address width

Ports:
clk         input   1       clock, all state on rising edge
rst         input   1       synchronous reset, active-high
req_valid   input   1       request present
req_ready   output  1       responder can accept request
req_we      input   1       1 = store, 0 = load
req_addr    input   ADDR_W  byte address (opr_res from LSU)
req_wdata   input   32      store data, already lane-aligned by LSU
req_wstrb   input   4       byte enables for store; ignored on load
rsp_valid   output  1       response present
rsp_ready   input   1       LSU accepts response
rsp_rdata   output  32      full word read; 0 for stores and errors
rsp_err     output  1       address out of range

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - req_ready=0 in the reset cycle, then 1 in IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards the in-flight request; a latched store is not written.
- Word index = req_addr[log2(DEPTH_WORDS)+1:2]; req_addr[1:0] ignored.
- Range check: out of range when req_addr[ADDR_W-1:2] >= DEPTH_WORDS.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/addr/wdata/wstrb and compute out-of-range.
  - Next state is WAIT if WAIT_STATES>0, else RESP.
- WAIT:
  - req_ready=0.
  - Counter counts 1..WAIT_STATES.
  - Go to RESP on the edge where the count reaches WAIT_STATES.
- Entering RESP (single edge, also the write edge):
  - Load, in range: rsp_rdata <= mem[idx].
  - Store, in range: mem[idx] byte lanes with wstrb[i]=1 updated; rsp_rdata <= 0.
  - Out of range: no RAM access, rsp_rdata <= 0, rsp_err <= 1.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err held stable until rsp_ready=1.
  - On rsp_ready=1: next state IDLE; rsp_valid, rsp_rdata, rsp_err cleared on that edge.
- Latency: load/store accept edge to rsp_valid = 1 + WAIT_STATES cycles.
- Throughput: at most one transaction per (2 + WAIT_STATES) cycles with rsp_ready tied high.
- Request held during busy: req_valid while not IDLE is ignored (req_ready=0). The requester holds its request stable until accepted.
- Store with wstrb=0: no RAM change, normal response.
- Read-after-write to the same word in consecutive transactions returns updated data.
- rsp_ready=1 while rsp_valid=0 has no effect.
- A store never responds with rsp_rdata ≠ 0.

Optional Feature:
- Macro: DMEM_RANGE_ERR_EN.
- Defined: range check as above; out-of-range requests return rsp_err=1, rsp_rdata=0, no write.
- Undefined:
  - No range check; index wraps modulo DEPTH_WORDS using only the low address bits.
  - rsp_err is tied to 0.
  - Every request accesses the RAM.

Test Plan:
- Reset, WAIT_STATES=1: assert rst 3 cycles mid-WAIT of a store of 0xDEADBEEF to 0x10. After release, load 0x10 -> rsp_rdata=0x00000000 (RAM pre-zeroed by bench); rsp_valid=0 and req_ready=0 during reset.
- Latency and data: store 0x12345678 wstrb=4'hF to 0x40, then load 0x40 with rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_rdata=0x12345678, rsp_err=0.
- Byte strobes: word 0x40=0x12345678; store 0x0000AB00 wstrb=4'b0010 -> load returns 0x1234AB78. Store wstrb=0 -> unchanged.
- Backpressure: load with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5; req_valid pulses in that window are not accepted; completion follows the first rsp_ready=1 edge.
- Out of range, DEPTH_WORDS=1024:
  - Macro defined: store to 0x1000 -> rsp_err=1, rsp_rdata=0, word 0 unchanged.
  - Macro undefined: same store writes word 0; rsp_err=0.
- WAIT_STATES=0 and 3: rsp_valid 1 and 4 cycles after accept respectively. Back-to-back loads with rsp_ready=1 accepted every 2 and 5 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data RAM serving LSU loads/stores through a
// valid/ready request channel and a valid/ready response channel. One
// transaction in flight; WAIT_STATES extra cycles between accept and response.
// Optional feature macro: DMEM_RANGE_ERR_EN (flag out-of-range addresses with
// rsp_err instead of wrapping the word index).
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             oor_q, oor_d;

  logic             accept, go_resp, wr_en, in_oor;
  logic             eff_we, eff_oor;
  logic [IDX_W-1:0] eff_idx;
  logic [31:0]      eff_wdata;
  logic [3:0]       eff_wstrb;
  logic             unused_addr;

  // Byte offset and (without range checking) upper address bits carry no meaning.
  assign unused_addr = ^req_addr;

`ifdef DMEM_RANGE_ERR_EN
  // DEPTH_WORDS is a power of two, so "word index >= DEPTH" is just any upper bit set.
  if (ADDR_W > IDX_W + 2) begin : g_rng
    assign in_oor = |req_addr[ADDR_W-1:IDX_W+2];
  end else begin : g_no_rng
    assign in_oor = 1'b0;
  end
`else
  assign in_oor = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && req_valid && req_ready_q;

  // With zero wait states the RAM access lands on the accept edge itself, so
  // the live request is used there instead of the latched copy.
  assign eff_we    = accept ? req_we              : we_q;
  assign eff_idx   = accept ? req_addr[IDX_W+1:2] : idx_q;
  assign eff_wdata = accept ? req_wdata           : wdata_q;
  assign eff_wstrb = accept ? req_wstrb           : wstrb_q;
  assign eff_oor   = accept ? in_oor              : oor_q;

  assign wr_en = go_resp && eff_we && !eff_oor;

  // Next-state, request latch and response data computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    oor_d       = oor_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    go_resp     = 1'b0;
    unique case (state_q)
      S_IDLE: if (accept) begin
        we_d    = req_we;
        idx_d   = req_addr[IDX_W+1:2];
        wdata_d = req_wdata;
        wstrb_d = req_wstrb;
        oor_d   = in_oor;
        cnt_d   = '0;
        if (WS == 4'd0) go_resp = 1'b1;
        else            state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == WS) go_resp = 1'b1;
      end
      S_RESP: if (rsp_ready) begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
    // Entering RESP: sample read data; stores and errors answer with zero.
    if (go_resp) begin
      state_d     = S_RESP;
      cnt_d       = '0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = eff_oor;
      rsp_rdata_d = (!eff_we && !eff_oor) ? mem[eff_idx] : '0;
    end
    req_ready_d = (state_d == S_IDLE);
  end

  // Control and registered outputs; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      we_q        <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      oor_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      we_q        <= we_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      oor_q       <= oor_d;
    end
  end

  // Byte-lane RAM write; contents survive reset, a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (eff_wstrb[i]) mem[eff_idx][8*i +: 8] <= eff_wdata[8*i +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver pushes expected responses from a
// word-array reference model; a monitor pops and compares each response.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int WS    = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  // side instances for wait-state 0 and 3 timing
  logic        xv [2], xwe [2], xrdy [2], xval [2], xerr [2];
  logic [31:0] xad [2], xwd [2], xrd [2];

  typedef struct { logic [31:0] rdata; logic err; int acc; } exp_t;
  exp_t exp_q [$];

  logic [31:0] mem_m [DEPTH];
  int cyc = 0, n_chk = 0, n_pass = 0, rdy_pct = 100, hold_n = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(xv[0]), .req_ready(xrdy[0]),
    .req_we(xwe[0]), .req_addr(xad[0]), .req_wdata(xwd[0]), .req_wstrb(4'hF),
    .rsp_valid(xval[0]), .rsp_ready(1'b1), .rsp_rdata(xrd[0]), .rsp_err(xerr[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .ADDR_W(32)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(xv[1]), .req_ready(xrdy[1]),
    .req_we(xwe[1]), .req_addr(xad[1]), .req_wdata(xwd[1]), .req_wstrb(4'hF),
    .rsp_valid(xval[1]), .rsp_ready(1'b1), .rsp_rdata(xrd[1]), .rsp_err(xerr[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Reference model: memory is a flat word array indexed by byte address / 4.
  function automatic void model(input logic we, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd, output logic err);
    longint unsigned w;
    int wi;
    w   = longint'(a) / 4;
    rd  = '0;
    err = 1'b0;
`ifdef DMEM_RANGE_ERR_EN
    if (w >= longint'(DEPTH)) begin
      err = 1'b1;
      return;
    end
`endif
    wi = int'(w % longint'(DEPTH));
    if (we) begin
      for (int b = 0; b < 4; b++) if (s[b]) mem_m[wi][8*b +: 8] = d[8*b +: 8];
    end else begin
      rd = mem_m[wi];
    end
  endfunction

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(99);
    if (r < 70)      return 32'(($urandom_range(63) << 2) | $urandom_range(3));
    else if (r < 85) return 32'($urandom_range(DEPTH*4-1));
    else             return $urandom | 32'h0000_1000;
  endfunction

  // Present a request, wait for acceptance, optionally log the expected response.
  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit push, output int acc);
    int t;
    exp_t e;
    t = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    while (!req_ready && t < 200) begin @(negedge clk); t++; end
    acc = cyc;
    if (!req_ready) begin
      n_chk++;
      $display("FAIL req_accept_timeout: req_ready low for 200 cycles, required high");
      req_valid = 1'b0;
    end else begin
      if (push) begin
        model(we, a, d, s, e.rdata, e.err);
        e.acc = acc;
        exp_q.push_back(e);
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Store then three loads on a side instance; check latency, data and spacing.
  task automatic xrun(input int k, input int w);
    int t, acc, pa;
    pa = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      xv[k] = 1'b1; xwe[k] = (n == 0); xad[k] = 32'h100; xwd[k] = 32'hA5C3_0000 + 32'(k);
      t = 0;
      while (!xrdy[k] && t < 100) begin @(negedge clk); t++; end
      acc = cyc;
      @(posedge clk);
      #1 xv[k] = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!xval[k] && t < 100);
      chk($sformatf("x%0d_latency", w), 32'(cyc - acc), 32'(1 + w));
      chk($sformatf("x%0d_rdata", w), xrd[k], (n == 0) ? 32'h0 : 32'hA5C3_0000 + 32'(k));
      chk($sformatf("x%0d_err", w), 32'(xerr[k]), 32'h0);
      if (n > 0) chk($sformatf("x%0d_interval", w), 32'(acc - pa), 32'(2 + w));
      pa = acc;
    end
  endtask

  // Monitor: compares every response cycle, owns rsp_ready.
  initial begin
    exp_t e;
    bit first, popped;
    first = 1'b1; popped = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        first = 1'b1; popped = 1'b0;
      end else if (popped) begin
        chk("rsp_valid_clear", 32'(rsp_valid), 32'h0);
        chk("rsp_rdata_clear", rsp_rdata, 32'h0);
        chk("rsp_err_clear", 32'(rsp_err), 32'h0);
        popped = 1'b0;
      end else if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_rsp_valid", 32'(rsp_valid), 32'h0);
        end else begin
          e = exp_q[0];
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (first) begin
            chk("latency", 32'(cyc - e.acc), 32'(1 + WS));
            first = 1'b0;
          end
        end
      end
      if (rsp_valid && hold_n > 0) begin
        rsp_ready = 1'b0;
        hold_n--;
      end else begin
        rsp_ready = ($urandom_range(99) < rdy_pct);
      end
      if (!rst && rsp_valid && rsp_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        first  = 1'b1;
        popped = 1'b1;
      end
    end
  end

  initial begin
    int acc, pa;
    for (int k = 0; k < 2; k++) begin
      xv[k] = 1'b0; xwe[k] = 1'b0; xad[k] = '0; xwd[k] = '0;
    end
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;

    // pre-zero RAM through the DUT
    for (int i = 0; i < DEPTH; i++) do_req(1'b1, 32'(i * 4), 32'h0, 4'hF, 1'b1, acc);
    do_req(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b1, acc);
    drain();

    // reset during WAIT of a store: store must be dropped, RAM kept
    do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, acc);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midrst_req_ready", 32'(req_ready), 32'h0);
    end
    rst = 1'b0;
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, acc);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, acc);

    // full store, partial strobe, zero strobe, read-after-write
    do_req(1'b1, 32'h40, 32'h1234_5678, 4'hF, 1'b1, acc);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, acc);
    do_req(1'b1, 32'h40, 32'h0000_AB00, 4'b0010, 1'b1, acc);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, acc);
    do_req(1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 1'b1, acc);
    do_req(1'b0, 32'h43, 32'h0, 4'h0, 1'b1, acc);

    // out of range store, then word 0
    do_req(1'b1, 32'h1000, 32'h55AA_55AA, 4'hF, 1'b1, acc);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc);
    drain();

    // backpressure: hold rsp_ready low 5 cycles, pulse requests while busy
    hold_n = 5;
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, acc);
    repeat (5) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_wdata = 32'hBAD0_BAD0; req_wstrb = 4'hF;
      chk("busy_req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    do_req(1'b0, 32'h44, 32'h0, 4'h0, 1'b1, acc);
    drain();

    // back-to-back loads with rsp_ready high
    pa = 0;
    for (int n = 0; n < 4; n++) begin
      do_req(1'b0, 32'h40, 32'h0, 4'h0, 1'b1, acc);
      if (n > 0) chk("b2b_interval", 32'(acc - pa), 32'(2 + WS));
      pa = acc;
    end
    drain();

    // randomized traffic with random response backpressure
    rdy_pct = 60;
    for (int n = 0; n < 400; n++) begin
      do_req(1'($urandom_range(1)), rnd_addr(), $urandom, 4'($urandom_range(15)), 1'b1, acc);
      repeat ($urandom_range(2)) @(negedge clk);
    end
    drain();
    rdy_pct = 100;

    // other wait-state settings
    xrun(0, 0);
    xrun(1, 3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
